disp_mux_gen_amisha: RTL and testbench
======================================

// Module: disp_mux_gen_amisha
// PURPOSE
//  Parametrised N-digit 7-segment time-multiplexer; next generation of the 4-digit display mux.
//  Scans N raw segment patterns onto shared cathodes with one-hot active-low anodes.
//  Adds programmable refresh rate, anti-ghost dead time, PWM brightness, per-digit blank/blink and a frame strobe.
//  Sits between the display-data logic (hex/BCD decoders) and the board pins.
// PARAMETERS
//  N_DIG    4      number of digits scanned (2..16)
//  DIV      50000  clock cycles per digit slot (>= DEAD+2)
//  DEAD     16     cycles at start of each slot with all anodes off (0..DIV-2)
//  BRT_W    4      brightness code width; PWM period = 2**BRT_W cycles
//  BLINK_W  6      frame-counter width; blink phase = MSB
// PORTS
//  clk_amisha      in   1          system clock, all logic on rising edge
//  reset_amisha    in   1          asynchronous, active-low reset
//  en_amisha       in   1          1 = scan runs; 0 = counters hold, all anodes off
//  in_amisha       in   8*N_DIG    raw patterns, digit k = [8k+7:8k], bit7 = dp, active-low segments
//  blank_amisha    in   N_DIG      1 = digit k permanently dark
//  blink_amisha    in   N_DIG      1 = digit k dark during blink phase
//  bright_amisha   in   BRT_W      on-duty = (bright+1)/2**BRT_W
//  an_amisha       out  N_DIG      anodes, active-low, at most one low
//  sseg_amisha     out  8          cathodes, active-low, {dp,g..a}
//  frame_amisha    out  1          1-cycle pulse when digit N_DIG-1 slot ends
// BEHAVIOUR
//  Reset (async, reset_amisha=0): an=all 1s, sseg=8'hFF, frame=0; slot cnt, digit idx, pwm cnt, frame cnt = 0.
//  Slot counter 0..DIV-1 increments each en cycle; at DIV-1 wraps to 0 and digit idx increments.
//  Digit idx wraps N_DIG-1 -> 0 (non-power-of-2 N legal); that wrap pulses frame and increments the blink counter (mod 2**BLINK_W).
//  pwm cnt is a free-running BRT_W-bit counter while en=1; on = (pwm cnt <= bright).
//  lit = en & (slot cnt >= DEAD) & on & ~blank[idx] & ~(blink[idx] & blink MSB).
//  an, sseg registered: 1-cycle latency from counters/inputs.
//    an <= lit ? ~(1<<idx) : all 1s.
//    sseg <= lit ? in[idx] : 8'hFF.
//  Inputs not captured; in/bright/blank/blink changes take effect on the next registered output.
//  en falling: next edge an=all 1s, sseg=FF, frame=0; counters frozen.
//  en rising: resume from the frozen counts.
//  bright = all 1s -> 100% duty within slot; no code gives 0% (use blank).
//  Reset mid-slot: outputs dark immediately (async); scan restarts at digit 0, slot 0.
//  Invariant: never two anodes low; dead time guarantees >= DEAD dark cycles between digits.
// STRUCTURE
//  Shared header disp_defs_amisha.vh:
//    SEG_OFF = 8'hFF, AN_OFF helper macro, clog2 function for idx width.
//  Sub-module disp_tick_gen_amisha: slot counter + digit index + frame pulse (params DIV, N_DIG).
//  Top holds PWM, blink counter, lit logic, output registers.
// TESTING (bench: N_DIG=4, DIV=4, DEAD=1, BRT_W=2, BLINK_W=2)
//  Scan order. in={8'h99,8'hA4,8'hF9,8'hC0}, bright=3, en=1, blank=blink=0.
//    -> an cycles 1110,1101,1011,0111 with sseg C0,F9,A4,99.
//    -> 1 dark cycle per slot; frame pulses every 16 cycles.
//  Brightness. bright=0 -> within each slot, an low only when pwm cnt=0 (1 in 4 cycles).
//  Brightness. bright=3 -> an low for all 3 non-dead cycles.
//  Blank/blink. blank=4'b0100 -> digit 2 never lights.
//  Blank/blink. blink=4'b0001 -> digit 0 lit in frames 0-1, dark in frames 2-3, repeating.
//  Enable. en=0 mid-slot -> next edge an=1111, sseg=FF; counters frozen.
//  Enable. en=1 -> scan resumes on same digit/slot count.
//  Reset. reset_amisha=0 mid-scan -> an=1111, sseg=FF without a clock edge.
//  Reset. release -> digit 0 slot restarts.
//  Non-power-of-2 and assertions. N_DIG=3: idx wraps 2->0, no an=1111 slot gap.
//  Assertions: popcount(~an)<=1 always.

Source files
------------

// File: rtl/disp_mux_gen_amisha_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment display driver.
package disp_mux_gen_amisha_pkg;

    // Cathode pattern with every segment (and dp) dark.
    localparam logic [7:0] SEG_OFF = 8'hFF;

    // Bits needed to count 0..n-1. Never less than 1, so n = 1 still gives a legal vector.
    function automatic int unsigned cnt_width(input int unsigned n);
        int unsigned w;
        w = 1;
        for (int unsigned i = 1; i < 32; i++) begin
            if ((32'd1 << i) < n) w = i + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/disp_mux_gen_amisha_tick_gen.sv
// Scan timebase: the slot counter, the digit index and a registered end-of-frame pulse.
module disp_mux_gen_amisha_tick_gen
    import disp_mux_gen_amisha_pkg::*;
#(
    parameter int unsigned DIV    = 50000,
    parameter int unsigned N_DIG  = 4,
    localparam int unsigned SlotW = cnt_width(DIV),
    localparam int unsigned IdxW  = cnt_width(N_DIG)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            en_i,
    output logic [SlotW-1:0] slot_o,
    output logic [IdxW-1:0]  idx_o,
    output logic            frame_end_o,
    output logic            frame_o
);

    localparam logic [SlotW-1:0] SlotLast = SlotW'(DIV - 1);
    localparam logic [IdxW-1:0]  IdxLast  = IdxW'(N_DIG - 1);

    logic [SlotW-1:0] slot_q, slot_d;
    logic [IdxW-1:0]  idx_q, idx_d;
    logic             frame_q, frame_d;
    logic             slot_end, idx_last;

    assign slot_end = (slot_q == SlotLast);
    assign idx_last = (idx_q == IdxLast);

    // Advance slot/digit while enabled; the explicit compare lets non-power-of-2 N_DIG wrap.
    always_comb begin
        slot_d  = slot_q;
        idx_d   = idx_q;
        frame_d = 1'b0;
        if (en_i) begin
            if (slot_end) begin
                slot_d  = '0;
                idx_d   = idx_last ? '0 : idx_q + 1'b1;
                frame_d = idx_last;
            end else begin
                slot_d = slot_q + 1'b1;
            end
        end
    end

    // Counter and frame-pulse state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            slot_q  <= '0;
            idx_q   <= '0;
            frame_q <= 1'b0;
        end else begin
            slot_q  <= slot_d;
            idx_q   <= idx_d;
            frame_q <= frame_d;
        end
    end

    assign slot_o      = slot_q;
    assign idx_o       = idx_q;
    assign frame_end_o = en_i & slot_end & idx_last;
    assign frame_o     = frame_q;

endmodule

// File: rtl/disp_mux_gen_amisha.sv
// N-digit 7-segment scanner with dead time, PWM brightness, per-digit blank/blink and frame strobe.
module disp_mux_gen_amisha
    import disp_mux_gen_amisha_pkg::*;
#(
    parameter int unsigned N_DIG   = 4,
    parameter int unsigned DIV     = 50000,
    parameter int unsigned DEAD    = 16,
    parameter int unsigned BRT_W   = 4,
    parameter int unsigned BLINK_W = 6
) (
    input  logic                 clk_amisha,
    input  logic                 reset_amisha,
    input  logic                 en_amisha,
    input  logic [8*N_DIG-1:0]   in_amisha,
    input  logic [N_DIG-1:0]     blank_amisha,
    input  logic [N_DIG-1:0]     blink_amisha,
    input  logic [BRT_W-1:0]     bright_amisha,
    output logic [N_DIG-1:0]     an_amisha,
    output logic [7:0]           sseg_amisha,
    output logic                 frame_amisha
);

    localparam int unsigned SlotW = cnt_width(DIV);
    localparam int unsigned IdxW  = cnt_width(N_DIG);
    localparam logic [SlotW-1:0] DeadCnt = SlotW'(DEAD);

    logic [SlotW-1:0]   slot;
    logic [IdxW-1:0]    idx;
    logic               frame_end;
    logic [BRT_W-1:0]   pwm_q;
    logic [BLINK_W-1:0] blink_q;
    logic [7:0]         sel_seg;
    logic               sel_blank, sel_blink, pwm_on, lit;
    logic [N_DIG-1:0]   an_d, an_q;
    logic [7:0]         sseg_d, sseg_q;

    disp_mux_gen_amisha_tick_gen #(
        .DIV   (DIV),
        .N_DIG (N_DIG)
    ) u_tick (
        .clk_i       (clk_amisha),
        .rst_ni      (reset_amisha),
        .en_i        (en_amisha),
        .slot_o      (slot),
        .idx_o       (idx),
        .frame_end_o (frame_end),
        .frame_o     (frame_amisha)
    );

    // Free-running PWM phase and blink frame counter; both freeze while disabled.
    always_ff @(posedge clk_amisha or negedge reset_amisha) begin
        if (!reset_amisha) begin
            pwm_q   <= '0;
            blink_q <= '0;
        end else begin
            if (en_amisha) pwm_q <= pwm_q + 1'b1;
            if (frame_end) blink_q <= blink_q + 1'b1;
        end
    end

    // Select the active digit's pattern and controls by compare, never indexing past N_DIG-1.
    always_comb begin
        sel_seg   = SEG_OFF;
        sel_blank = 1'b0;
        sel_blink = 1'b0;
        for (int k = 0; k < N_DIG; k++) begin
            if (idx == IdxW'(k)) begin
                sel_seg   = in_amisha[8*k +: 8];
                sel_blank = blank_amisha[k];
                sel_blink = blink_amisha[k];
            end
        end
    end

    // Light only outside dead time, inside the PWM on-window and when not blanked/blinked off.
    always_comb begin
        pwm_on = (pwm_q <= bright_amisha);
        lit    = en_amisha & (slot >= DeadCnt) & pwm_on & ~sel_blank
                 & ~(sel_blink & blink_q[BLINK_W-1]);
        for (int k = 0; k < N_DIG; k++) begin
            an_d[k] = ~(lit & (idx == IdxW'(k)));
        end
        sseg_d = lit ? sel_seg : SEG_OFF;
    end

    // Registered pin drivers; reset forces them dark without waiting for a clock.
    always_ff @(posedge clk_amisha or negedge reset_amisha) begin
        if (!reset_amisha) begin
            an_q   <= '1;
            sseg_q <= SEG_OFF;
        end else begin
            an_q   <= an_d;
            sseg_q <= sseg_d;
        end
    end

    assign an_amisha   = an_q;
    assign sseg_amisha = sseg_q;

endmodule

// File: tb/tb_disp_mux_gen_amisha.sv
// Bench for disp_mux_gen_amisha: a 4-digit instance exercised fully, plus a 3-digit instance.
module tb_disp_mux_gen_amisha;

    localparam int N    = 4;
    localparam int N3   = 3;
    localparam int DIV  = 4;
    localparam int DEAD = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        en;
    logic [31:0] din;
    logic [23:0] din3;
    logic [3:0]  blank, blink;
    logic [1:0]  bright;
    logic [3:0]  an;
    logic [7:0]  sseg;
    logic        frame;
    logic [2:0]  an3;
    logic [7:0]  sseg3;
    logic        frame3;

    int n_vec = 0;
    int n_err = 0;

    typedef struct packed {
        logic [3:0] an;
        logic [7:0] sseg;
        logic       frame;
        logic [2:0] an3;
        logic [7:0] sseg3;
        logic       frame3;
    } exp_t;

    exp_t sb[$];

    // Reference state: main instance and the always-enabled 3-digit instance.
    int m_slot, m_idx, m_pwm, m_blk;
    int m3_slot, m3_idx;

    disp_mux_gen_amisha #(
        .N_DIG(N), .DIV(DIV), .DEAD(DEAD), .BRT_W(2), .BLINK_W(2)
    ) u_dut (
        .clk_amisha    (clk),
        .reset_amisha  (rst_n),
        .en_amisha     (en),
        .in_amisha     (din),
        .blank_amisha  (blank),
        .blink_amisha  (blink),
        .bright_amisha (bright),
        .an_amisha     (an),
        .sseg_amisha   (sseg),
        .frame_amisha  (frame)
    );

    disp_mux_gen_amisha #(
        .N_DIG(N3), .DIV(DIV), .DEAD(DEAD), .BRT_W(2), .BLINK_W(2)
    ) u_dut3 (
        .clk_amisha    (clk),
        .reset_amisha  (rst_n),
        .en_amisha     (1'b1),
        .in_amisha     (din3),
        .blank_amisha  (3'b000),
        .blink_amisha  (3'b000),
        .bright_amisha (2'b11),
        .an_amisha     (an3),
        .sseg_amisha   (sseg3),
        .frame_amisha  (frame3)
    );

    always #5 clk = ~clk;

    // At most one anode may be low at any time, on either instance.
    always @(negedge clk) begin
        n_vec++;
        assert ($countones(~an) <= 1 && $countones(~an3) <= 1) else begin
            n_err++;
            $error("FAIL onehot_an observed an=%b an3=%b expected popcount<=1", an, an3);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_slot = 0; m_idx = 0; m_pwm = 0; m_blk = 0;
        m3_slot = 0; m3_idx = 0;
    endtask

    // One clock: predict the registered outputs from pre-edge state, then compare after the edge.
    task automatic step();
        exp_t e;
        bit   lit, lit3;
        if (!rst_n) begin
            e = '{an: 4'hF, sseg: 8'hFF, frame: 1'b0, an3: 3'h7, sseg3: 8'hFF, frame3: 1'b0};
        end else begin
            lit = en && (m_slot >= DEAD) && (m_pwm <= int'(bright)) && !blank[m_idx]
                  && !(blink[m_idx] && (m_blk >= 2));
            e.an    = lit ? ~(4'b0001 << m_idx) : 4'hF;
            e.sseg  = lit ? din[m_idx*8 +: 8] : 8'hFF;
            e.frame = en && (m_slot == DIV-1) && (m_idx == N-1);
            lit3     = (m3_slot >= DEAD);
            e.an3    = lit3 ? ~(3'b001 << m3_idx) : 3'h7;
            e.sseg3  = lit3 ? din3[m3_idx*8 +: 8] : 8'hFF;
            e.frame3 = (m3_slot == DIV-1) && (m3_idx == N3-1);
        end
        sb.push_back(e);
        @(posedge clk);
        if (rst_n) begin
            if (en) begin
                m_pwm = (m_pwm + 1) % 4;
                if (m_slot == DIV-1) begin
                    m_slot = 0;
                    if (m_idx == N-1) begin
                        m_idx = 0;
                        m_blk = (m_blk + 1) % 4;
                    end else m_idx++;
                end else m_slot++;
            end
            if (m3_slot == DIV-1) begin
                m3_slot = 0;
                m3_idx  = (m3_idx == N3-1) ? 0 : m3_idx + 1;
            end else m3_slot++;
        end
        #1;
        e = sb.pop_front();
        check("an", 32'(an), 32'(e.an));
        check("sseg", 32'(sseg), 32'(e.sseg));
        check("frame", 32'(frame), 32'(e.frame));
        check("an3", 32'(an3), 32'(e.an3));
        check("sseg3", 32'(sseg3), 32'(e.sseg3));
        check("frame3", 32'(frame3), 32'(e.frame3));
    endtask

    initial begin
        int cnt;
        en     = 1'b1;
        din    = 32'h99A4F9C0;
        din3   = 24'hA4F9C0;
        blank  = 4'b0000;
        blink  = 4'b0000;
        bright = 2'd3;

        // Reset state is visible before any clock edge.
        #1 rst_n = 1'b0;
        #1;
        check("rst_an", 32'(an), 32'h0000000F);
        check("rst_sseg", 32'(sseg), 32'h000000FF);
        check("rst_frame", 32'(frame), 32'h0);
        check("rst_an3", 32'(an3), 32'h00000007);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Scan order and frame strobe.
        cnt = 0;
        for (int i = 1; i <= 32; i++) begin
            step();
            if (frame) cnt++;
            if (i == 2)  begin check("scan0_an", 32'(an), 32'hE); check("scan0_seg", 32'(sseg), 32'hC0); end
            if (i == 6)  begin check("scan1_an", 32'(an), 32'hD); check("scan1_seg", 32'(sseg), 32'hF9); end
            if (i == 10) begin check("scan2_an", 32'(an), 32'hB); check("scan2_seg", 32'(sseg), 32'hA4); end
            if (i == 14) begin check("scan3_an", 32'(an), 32'h7); check("scan3_seg", 32'(sseg), 32'h99); end
        end
        check("frame_count", 32'(cnt), 32'd2);

        // Blank digit 2 for a full frame.
        blank = 4'b0100;
        cnt = 0;
        for (int i = 0; i < 16; i++) begin step(); if (an == 4'b1011) cnt++; end
        check("blank_dig2", 32'(cnt), 32'd0);
        blank = 4'b0000;

        // pwm and slot counters advance in lockstep here (both period 4), so pwm==0 always
        // falls in the dead cycle and bright=0 leaves the display dark.
        bright = 2'd0;
        cnt = 0;
        for (int i = 0; i < 16; i++) begin step(); if (an != 4'hF) cnt++; end
        check("bright0_lit", 32'(cnt), 32'd0);
        bright = 2'd1;
        cnt = 0;
        for (int i = 0; i < 16; i++) begin step(); if (an != 4'hF) cnt++; end
        check("bright1_lit", 32'(cnt), 32'd4);
        bright = 2'd3;
        cnt = 0;
        for (int i = 0; i < 16; i++) begin step(); if (an != 4'hF) cnt++; end
        check("bright3_lit", 32'(cnt), 32'd12);

        // Asynchronous reset mid-scan.
        step();
        step();
        #1 rst_n = 1'b0;
        #1;
        check("midrst_an", 32'(an), 32'h0000000F);
        check("midrst_sseg", 32'(sseg), 32'h000000FF);
        check("midrst_frame", 32'(frame), 32'h0);
        check("midrst_an3", 32'(an3), 32'h00000007);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Blink digit 0: lit in frames 0-1, dark in frames 2-3.
        blink = 4'b0001;
        cnt = 0;
        for (int i = 1; i <= 64; i++) begin
            step();
            if (i == 2) check("restart_dig0", 32'(an), 32'hE);
            if (an == 4'b1110) cnt++;
        end
        check("blink_dig0", 32'(cnt), 32'd6);
        blink = 4'b0000;

        // Enable drop mid-slot (digit 1, slot 2), hold, then resume on the same count.
        for (int i = 0; i < 6; i++) step();
        en = 1'b0;
        step();
        check("en0_an", 32'(an), 32'hF);
        check("en0_sseg", 32'(sseg), 32'hFF);
        check("en0_frame", 32'(frame), 32'h0);
        step();
        step();
        en = 1'b1;
        step();
        check("resume_an", 32'(an), 32'hD);
        check("resume_seg", 32'(sseg), 32'hF9);
        for (int i = 0; i < 8; i++) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
